button_debouncer: RTL and testbench

//  Conditions the raw, asynchronous, bouncing board buttons (BTN[1:0]) before

---
 rtl/button_debouncer_if.sv | 28 ++
 rtl/button_debouncer.sv | 103 ++++++++++
 tb/tb_button_debouncer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// Button bundle between the raw board pins and the cleaned-up outputs.
// The master side drives the raw pins and consumes the conditioned signals.
// The slave side is the debouncer itself.
interface button_debouncer_if #(
    parameter int N_BTN = 2
);
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );
endinterface

// File: rtl/button_debouncer.sv
// Per-button conditioning of raw bouncing board buttons: a 2-flop
// synchronizer, a debounce window counter, a clean level, one-cycle
// press/release strobes and a one-shot long-press strobe.
// Every button bit is handled independently of the others.
module button_debouncer #(
    parameter int N_BTN      = 2,
    parameter int CNT_WIDTH  = 17,
    parameter int HOLD_WIDTH = 24
) (
    input  logic              CLK,
    input  logic              reset,
    button_debouncer_if.slave btn_if
);

    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
    localparam logic [HOLD_WIDTH-1:0] HOLD_MAX = '1;

    logic [N_BTN-1:0]      s1_q, s1_d;
    logic [N_BTN-1:0]      s2_q, s2_d;
    logic [N_BTN-1:0]      level_q, level_d;
    logic [N_BTN-1:0]      press_q, press_d;
    logic [N_BTN-1:0]      release_q, release_d;
    logic [N_BTN-1:0]      long_q, long_d;
    logic [N_BTN-1:0]      long_done_q, long_done_d;
    logic [CNT_WIDTH-1:0]  cnt_q  [N_BTN];
    logic [CNT_WIDTH-1:0]  cnt_d  [N_BTN];
    logic [HOLD_WIDTH-1:0] hold_q [N_BTN];
    logic [HOLD_WIDTH-1:0] hold_d [N_BTN];

    // Next-state logic: synchronize, count the disagreement window, derive strobes and the hold timer.
    always_comb begin
        s1_d        = btn_if.btn_in;
        s2_d        = s1_q;
        level_d     = level_q;
        press_d     = '0;
        release_d   = '0;
        long_d      = '0;
        long_done_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i]  = '0;
            hold_d[i] = '0;

            // A single cycle of agreement throws the window away and starts over.
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end

            // Strobes are computed from the level transition so they line up with the level change.
            press_d[i]   = level_d[i] & ~level_q[i];
            release_d[i] = ~level_d[i] & level_q[i];

            // The hold timer saturates; long_done remembers the strobe already fired until release.
            if (level_q[i]) begin
                if (hold_q[i] != HOLD_MAX) begin
                    hold_d[i] = hold_q[i] + 1'b1;
                end else begin
                    hold_d[i] = hold_q[i];
                end
            end
            long_d[i]      = level_q[i] & (hold_q[i] == HOLD_MAX) & ~long_done_q[i];
            long_done_d[i] = level_q[i] & (hold_q[i] == HOLD_MAX);
        end
    end

    // State registers; reset wins over any debounce or hold in progress.
    always_ff @(posedge CLK) begin
        if (reset) begin
            s1_q        <= '0;
            s2_q        <= '0;
            level_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
            long_q      <= '0;
            long_done_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i]  <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            long_done_q <= long_done_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i]  <= cnt_d[i];
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign btn_if.btn_level   = level_q;
    assign btn_if.btn_press   = press_q;
    assign btn_if.btn_release = release_q;
    assign btn_if.btn_long    = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer with a short debounce window
// (16 clocks) and a short long-press threshold (64 clocks).
module tb_button_debouncer;

    localparam int N_BTN      = 2;
    localparam int CNT_WIDTH  = 4;
    localparam int HOLD_WIDTH = 6;
    localparam int DEB_LAT    = 18;
    localparam int LONG_LAT   = 64;
    localparam int K_PRESS    = 0;
    localparam int K_RELEASE  = 1;
    localparam int K_LONG     = 2;

    typedef struct {
        int cyc;
        int kind;
        int bitn;
    } ev_t;

    logic CLK = 1'b0;
    logic reset = 1'b1;
    logic rst_q = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  expq[$];
    logic [N_BTN-1:0] lvl_exp = '0;

    button_debouncer_if #(.N_BTN(N_BTN)) bif ();

    button_debouncer #(
        .N_BTN     (N_BTN),
        .CNT_WIDTH (CNT_WIDTH),
        .HOLD_WIDTH(HOLD_WIDTH)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .btn_if(bif.slave)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    // Cycle counter and a copy of the reset the DUT just sampled.
    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic checkOutput(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d want=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int evKey(input ev_t e);
        return e.cyc * 16 + e.kind * 4 + e.bitn;
    endfunction

    task automatic pushEv(input int c, input int kind, input int bitn);
        ev_t e;
        int idx;
        e.cyc  = c;
        e.kind = kind;
        e.bitn = bitn;
        idx = expq.size();
        for (int i = 0; i < expq.size(); i++) begin
            if (evKey(expq[i]) > evKey(e)) begin
                idx = i;
                break;
            end
        end
        expq.insert(idx, e);
    endtask

    task automatic applyEv(input ev_t e);
        if (e.kind == K_PRESS)   lvl_exp[e.bitn] = 1'b1;
        if (e.kind == K_RELEASE) lvl_exp[e.bitn] = 1'b0;
    endtask

    // Drive the raw pins just after an edge and keep them for n sampling edges.
    // Returns the cycle number at which the value was driven.
    task automatic applyStimulus(input logic [N_BTN-1:0] v, input int n, output int drv);
        @(posedge CLK);
        #2;
        bif.btn_in = v;
        drv = cyc;
        repeat (n - 1) @(posedge CLK);
    endtask

    // Monitor: pops expected events as strobes appear and tracks the expected level.
    initial begin
        ev_t e;
        logic obs;
        forever begin
            @(negedge CLK);
            if (rst_q) begin
                lvl_exp = '0;
            end else begin
                while (expq.size() > 0 && expq[0].cyc < cyc) begin
                    e = expq.pop_front();
                    checkOutput("missed_event", -1, e.kind * 4 + e.bitn);
                    applyEv(e);
                end
                for (int k = 0; k < 3; k++) begin
                    for (int b = 0; b < N_BTN; b++) begin
                        obs = (k == K_PRESS)   ? bif.btn_press[b] :
                              (k == K_RELEASE) ? bif.btn_release[b] : bif.btn_long[b];
                        if (obs) begin
                            if (expq.size() > 0) begin
                                e = expq.pop_front();
                                checkOutput("event_cycle", cyc, e.cyc);
                                checkOutput("event_kind_bit", k * 4 + b, e.kind * 4 + e.bitn);
                                applyEv(e);
                            end else begin
                                checkOutput("unexpected_strobe", k * 4 + b, -1);
                            end
                        end
                    end
                end
                checkOutput("level", int'(bif.btn_level), int'(lvl_exp));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        int d;
        int p;
        int e_rst;
        bif.btn_in = '0;

        // Reset for 3 clocks with buttons idle.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("rst_level",   int'(bif.btn_level),   0);
        checkOutput("rst_press",   int'(bif.btn_press),   0);
        checkOutput("rst_release", int'(bif.btn_release), 0);
        checkOutput("rst_long",    int'(bif.btn_long),    0);
        @(posedge CLK);
        #2;
        reset = 1'b0;
        $display("[TB] reset released at cycle %0d", cyc);
        applyStimulus(2'b00, 50, d);

        // Single clean press on bit 0, then release.
        applyStimulus(2'b01, 1, d);
        pushEv(d + DEB_LAT, K_PRESS, 0);
        repeat (39) @(posedge CLK);
        applyStimulus(2'b00, 1, d);
        pushEv(d + DEB_LAT, K_RELEASE, 0);
        repeat (29) @(posedge CLK);

        // Bouncing: 10-clock high bursts never complete a window.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b01, 10, d);
            applyStimulus(2'b00, 4, d);
        end

        // Steady high after the last bounce, held long enough for a single long strobe.
        applyStimulus(2'b01, 1, d);
        p = d + DEB_LAT;
        pushEv(p, K_PRESS, 0);
        pushEv(p + LONG_LAT, K_LONG, 0);
        repeat (DEB_LAT + 100 - 1) @(posedge CLK);
        applyStimulus(2'b00, 1, d);
        pushEv(d + DEB_LAT, K_RELEASE, 0);
        repeat (29) @(posedge CLK);

        // Short press: released 30 clocks after the press strobe, no long strobe.
        applyStimulus(2'b01, 1, d);
        p = d + DEB_LAT;
        pushEv(p, K_PRESS, 0);
        repeat (DEB_LAT + 30 - 1) @(posedge CLK);
        applyStimulus(2'b00, 1, d);
        pushEv(d + DEB_LAT, K_RELEASE, 0);
        repeat (29) @(posedge CLK);

        // Both buttons pressed together, then released together.
        applyStimulus(2'b11, 1, d);
        pushEv(d + DEB_LAT, K_PRESS, 0);
        pushEv(d + DEB_LAT, K_PRESS, 1);
        repeat (29) @(posedge CLK);
        applyStimulus(2'b00, 1, d);
        pushEv(d + DEB_LAT, K_RELEASE, 0);
        pushEv(d + DEB_LAT, K_RELEASE, 1);
        repeat (29) @(posedge CLK);

        // Reset lands in the middle of a debounce window while the button stays held.
        applyStimulus(2'b01, 12, d);
        @(posedge CLK);
        #2;
        reset = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("mid_rst_level", int'(bif.btn_level), 0);
        checkOutput("mid_rst_press", int'(bif.btn_press), 0);
        @(posedge CLK);
        #2;
        reset = 1'b0;
        e_rst = cyc;
        pushEv(e_rst + DEB_LAT, K_PRESS, 0);
        repeat (30) @(posedge CLK);

        // Everything pushed must have been seen by now.
        @(negedge CLK);
        checkOutput("queue_empty", expq.size(), 0);
        checkOutput("final_level", int'(bif.btn_level), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
